// File: rtl/ring_output_channel.sv
// Output-channel stage of the ring router: captures the arbitration winner into a
// per-VC slot (even/odd) and sends it downstream with a send/ready handshake.
module ring_output_channel #(
   parameter int DATA_WIDTH = 64,
   parameter int HOP_LSB    = 48,
   parameter int HOP_WIDTH  = 8,
   parameter int SHIFT_HOP  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  polarity,
   input  logic                  win0,
   input  logic                  win1,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic [DATA_WIDTH-1:0] in1_data,
   output logic                  output_empty_even,
   output logic                  output_empty_odd,
   input  logic                  ro,
   output logic                  so,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [15:0]           pkt_count,
   output logic                  protocol_err
);

   logic [1:0]            valid_q;
   logic [DATA_WIDTH-1:0] data_q [2];
   logic                  w_idx;
   logic                  r_idx;
   logic                  any_win;
   logic                  one_win;
   logic                  write_ok;
   logic                  err_now;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] cap_data;

   // The slot matching polarity is the write slot; the other one is the send slot.
   assign w_idx = polarity;
   assign r_idx = ~polarity;

   assign any_win  = win0 | win1;
   assign one_win  = win0 ^ win1;
   assign write_ok = one_win & ~valid_q[w_idx];
   assign err_now  = (win0 & win1) | (any_win & valid_q[w_idx]);

   always_comb begin
      sel_data = win0 ? in0_data : in1_data;
      cap_data = sel_data;
      if (SHIFT_HOP != 0)
         cap_data[HOP_LSB +: HOP_WIDTH] = sel_data[HOP_LSB +: HOP_WIDTH] >> 1;
   end

   assign output_empty_even = ~valid_q[0];
   assign output_empty_odd  = ~valid_q[1];

   // Handshake: a transfer happens on every posedge where so is high; so is
   // asserted exactly when the send slot holds a packet and ro is high.
   assign so       = valid_q[r_idx] & ro;
   assign data_out = valid_q[r_idx] ? data_q[r_idx] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= 2'b00;
         data_q[0]    <= '0;
         data_q[1]    <= '0;
         pkt_count    <= 16'd0;
         protocol_err <= 1'b0;
      end else begin
         if (write_ok) begin
            data_q[w_idx]  <= cap_data;
            valid_q[w_idx] <= 1'b1;
         end
         if (so) begin
            valid_q[r_idx] <= 1'b0;
            pkt_count      <= pkt_count + 16'd1;
         end
         if (err_now)
            protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ring_output_channel.sv
// Directed bench for ring_output_channel: reset, single hop, backpressure/overflow,
// double grant, streaming, pkt_count wrap and reset mid-operation.
module tb_ring_output_channel;

   logic        clk;
   logic        reset;
   logic        polarity;
   logic        win0;
   logic        win1;
   logic [63:0] in0_data;
   logic [63:0] in1_data;
   logic        output_empty_even;
   logic        output_empty_odd;
   logic        ro;
   logic        so;
   logic [63:0] data_out;
   logic [15:0] pkt_count;
   logic        protocol_err;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   ring_output_channel dut (
      .clk               (clk),
      .reset             (reset),
      .polarity          (polarity),
      .win0              (win0),
      .win1              (win1),
      .in0_data          (in0_data),
      .in1_data          (in1_data),
      .output_empty_even (output_empty_even),
      .output_empty_odd  (output_empty_odd),
      .ro                (ro),
      .so                (so),
      .data_out          (data_out),
      .pkt_count         (pkt_count),
      .protocol_err      (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] shift_hop(input logic [63:0] d);
      logic [63:0] r;
      r = d;
      r[55:48] = d[55:48] >> 1;
      return r;
   endfunction

   initial begin
      logic [63:0] d;
      logic [63:0] e;

      reset = 1'b1; polarity = 1'b0; win0 = 1'b0; win1 = 1'b0;
      in0_data = '0; in1_data = '0; ro = 1'b1;

      // Reset
      tick(); tick();
      check("rst_empty_even", 64'(output_empty_even), 64'd1);
      check("rst_empty_odd",  64'(output_empty_odd),  64'd1);
      check("rst_so",         64'(so),                64'd0);
      check("rst_data_out",   data_out,               64'd0);
      check("rst_pkt_count",  64'(pkt_count),         64'd0);
      check("rst_err",        64'(protocol_err),      64'd0);
      reset = 1'b0;

      // Single hop
      polarity = 1'b0; win0 = 1'b1; in0_data = 64'h000F_0000_0000_00AA;
      tick();
      win0 = 1'b0;
      check("hop_empty_even", 64'(output_empty_even), 64'd0);
      polarity = 1'b1; ro = 1'b1;
      #1;
      check("hop_so",         64'(so),                64'd1);
      check("hop_data_out",   data_out,               64'h0007_0000_0000_00AA);
      tick();
      check("hop_drained",    64'(output_empty_even), 64'd1);
      check("hop_count",      64'(pkt_count),         64'd1);
      check("hop_so_after",   64'(so),                64'd0);

      // Backpressure and overflow
      polarity = 1'b0; ro = 1'b0; win0 = 1'b1; in0_data = 64'h0123_4567_89AB_CDEF;
      tick();
      win0 = 1'b0; polarity = 1'b1;
      #1;
      check("bp_so_held",     64'(so),                64'd0);
      tick();
      check("bp_retained",    64'(output_empty_even), 64'd0);
      check("bp_count",       64'(pkt_count),         64'd1);
      polarity = 1'b0; win1 = 1'b1; in1_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      win1 = 1'b0;
      check("ovf_err",        64'(protocol_err),      64'd1);
      check("ovf_full",       64'(output_empty_even), 64'd0);
      polarity = 1'b1; ro = 1'b1;
      #1;
      check("ovf_no_overwrite", data_out,             64'h0111_4567_89AB_CDEF);
      tick();
      check("ovf_count",      64'(pkt_count),         64'd2);
      check("err_sticky",     64'(protocol_err),      64'd1);

      // Double grant on an empty slot
      reset = 1'b1; tick(); reset = 1'b0;
      check("dg_err_cleared", 64'(protocol_err),      64'd0);
      polarity = 1'b0; win0 = 1'b1; win1 = 1'b1;
      in0_data = 64'h1111_1111_1111_1111; in1_data = 64'h2222_2222_2222_2222;
      tick();
      win0 = 1'b0; win1 = 1'b0;
      check("dg_empty",       64'(output_empty_even), 64'd1);
      check("dg_err",         64'(protocol_err),      64'd1);

      // Streaming: toggle polarity, alternate winners, ro high
      reset = 1'b1; tick(); reset = 1'b0;
      ro = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d = {8'h5A, 8'h80 | 8'(i), 32'h0, 16'(i)};
         polarity = i[0];
         win0 = ~i[0]; win1 = i[0];
         in0_data = d; in1_data = d;
         #1;
         if (i == 0) begin
            check("strm_so_first", 64'(so), 64'd0);
         end else begin
            check("strm_so", 64'(so), 64'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
            check("strm_data", data_out, e);
         end
         exp_q.push_back(shift_hop(d));
         tick();
      end
      check("strm_count", 64'(pkt_count), 64'd19);
      check("strm_err",   64'(protocol_err), 64'd0);
      exp_q.delete();

      // Push pkt_count up to 0xFFFF, then wrap with one more send
      for (int i = 20; i < 65536; i++) begin
         polarity = i[0];
         win0 = 1'b1; win1 = 1'b0;
         in0_data = 64'(i);
         tick();
      end
      check("wrap_pre",  64'(pkt_count), 64'hFFFF);
      polarity = 1'b0; win0 = 1'b1; in0_data = 64'h0000_0000_0000_0077;
      tick();
      check("wrap_zero", 64'(pkt_count), 64'd0);

      // Fill both slots, then reset mid-operation
      polarity = 1'b1; ro = 1'b0; win0 = 1'b1; in0_data = 64'h0000_0000_0000_0088;
      tick();
      win0 = 1'b0;
      check("fill_even", 64'(output_empty_even), 64'd0);
      check("fill_odd",  64'(output_empty_odd),  64'd0);
      reset = 1'b1; ro = 1'b1;
      tick();
      check("mid_rst_even",  64'(output_empty_even), 64'd1);
      check("mid_rst_odd",   64'(output_empty_odd),  64'd1);
      check("mid_rst_so",    64'(so),                64'd0);
      check("mid_rst_count", 64'(pkt_count),         64'd0);
      check("mid_rst_data",  data_out,               64'd0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
